// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// IFETCH_MISALIGN_EXC_EN adds a per-entry misalignment exception flag.
package ifetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
`ifdef IFETCH_MISALIGN_EXC_EN
    logic            exc;
`endif
  } fq_entry_t;

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Used for both the outstanding-address FIFO and the instruction queue.
module fetch_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  // Explicit wrap keeps non-power-of-2 depths (e.g. MAX_OUT=3) correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_inc(wr_q);
      if (pop_ok)  rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited imem requests, response queue, redirect flush.
// IFETCH_MISALIGN_EXC_EN turns misaligned PCs into NOP entries flagged with id_exc.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_jmp,
  output logic            pc_rel,
  output logic [XLEN-1:0] pc_nxt,
  input  logic            redir_vld,
  input  logic [XLEN-1:0] redir_tgt,
  output logic            imem_req_vld,
  input  logic            imem_req_rdy,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_vld,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_vld,
  input  logic            id_rdy,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst
`ifdef IFETCH_MISALIGN_EXC_EN
  ,
  output logic            id_exc
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(MAX_OUT + 1);
  localparam int unsigned QW = $bits(fq_entry_t);

  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, q_count;
  logic [AW-1:0]   a_count;
  logic [CW:0]     occ;
  logic            credit_ok, req_fire, rsp_ok, discard, q_push, q_pop;
  logic [XLEN-1:0] a_dout;
  logic [QW-1:0]   q_din_raw, q_dout_raw;
  fq_entry_t       q_din, q_dout;
`ifdef IFETCH_MISALIGN_EXC_EN
  logic            stall_q, stall_d, misalign, mis_push;
`endif

  always_comb begin
    occ       = {1'b0, inflight_q} + {1'b0, q_count};
    credit_ok = (occ < (CW+1)'(DEPTH)) && (inflight_q < CW'(MAX_OUT));
`ifdef IFETCH_MISALIGN_EXC_EN
    misalign     = (pc_cur[1:0] != 2'b00);
    // Only inject once older responses have landed so queue order stays program order.
    mis_push     = !rst && credit_ok && !redir_vld && !stall_q && misalign
                   && (inflight_q == '0);
    imem_req_vld = !rst && credit_ok && !redir_vld && !stall_q && !misalign;
`else
    imem_req_vld = !rst && credit_ok && !redir_vld;
`endif
    req_fire = imem_req_vld && imem_req_rdy;
    rsp_ok   = imem_rsp_vld && (inflight_q != '0);
    discard  = (drop_q != '0) || redir_vld;
    q_pop    = id_vld && id_rdy;

    q_push       = rsp_ok && !discard;
    q_din        = '0;
    q_din.pc     = a_dout;
    q_din.inst   = imem_rsp_data;
`ifdef IFETCH_MISALIGN_EXC_EN
    if (mis_push) begin
      q_push     = 1'b1;
      q_din.pc   = pc_cur;
      q_din.inst = INST_NOP;
      q_din.exc  = 1'b1;
    end
    stall_d = redir_vld ? 1'b0 : (stall_q || mis_push);
`endif
    q_din_raw = q_din;

    case ({req_fire, rsp_ok})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Redirect overrides the per-response decrement: everything still out is stale.
    if (redir_vld)                     drop_d = inflight_d;
    else if (rsp_ok && drop_q != '0)   drop_d = drop_q - CW'(1);
    else                               drop_d = drop_q;

    if (rst) begin
      pc_jmp = 1'b1;
      pc_rel = 1'b1;
      pc_nxt = '0;
    end else if (redir_vld) begin
      pc_jmp = 1'b1;
      pc_rel = 1'b0;
      pc_nxt = redir_tgt;
    end else if (req_fire) begin
      pc_jmp = 1'b0;
      pc_rel = 1'b1;
      pc_nxt = '0;
    end else begin
      pc_jmp = 1'b1;
      pc_rel = 1'b1;
      pc_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      drop_q     <= '0;
`ifdef IFETCH_MISALIGN_EXC_EN
      stall_q    <= 1'b0;
`endif
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
`ifdef IFETCH_MISALIGN_EXC_EN
      stall_q    <= stall_d;
`endif
    end
  end

  fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUT)) u_addr_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_fire),
    .din_i   (pc_cur),
    .pop_i   (rsp_ok),
    .flush_i (1'b0),
    .dout_o  (a_dout),
    .count_o (a_count)
  );

  fetch_fifo #(.W(QW), .DEPTH(DEPTH)) u_inst_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (q_push),
    .din_i   (q_din_raw),
    .pop_i   (q_pop),
    .flush_i (redir_vld),
    .dout_o  (q_dout_raw),
    .count_o (q_count)
  );

  assign q_dout        = fq_entry_t'(q_dout_raw);
  assign imem_req_addr = pc_cur;
  assign id_vld        = (q_count != '0);
  assign id_pc         = q_dout.pc;
  assign id_inst       = q_dout.inst;
`ifdef IFETCH_MISALIGN_EXC_EN
  assign id_exc        = q_dout.exc;
`endif

  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_vld |-> (inflight_q != '0));
  a_inflight_max: assert property (@(posedge clk) disable iff (rst)
    inflight_q <= CW'(MAX_OUT));
  a_addr_track: assert property (@(posedge clk) disable iff (rst)
    CW'(a_count) == inflight_q);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: models the pc module and an in-order imem.
module tb_ifetch;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned MAX_OUT = 2;

  logic        clk, rst;
  logic [31:0] pc_cur, pc_nxt, redir_tgt, imem_req_addr, imem_rsp_data, id_pc, id_inst;
  logic        pc_jmp, pc_rel, redir_vld, imem_req_vld, imem_req_rdy, imem_rsp_vld;
  logic        id_vld, id_rdy;
`ifdef IFETCH_MISALIGN_EXC_EN
  logic        id_exc;
`endif

  ifetch #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .pc_jmp        (pc_jmp),
    .pc_rel        (pc_rel),
    .pc_nxt        (pc_nxt),
    .redir_vld     (redir_vld),
    .redir_tgt     (redir_tgt),
    .imem_req_vld  (imem_req_vld),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_data (imem_rsp_data),
    .id_vld        (id_vld),
    .id_rdy        (id_rdy),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
`ifdef IFETCH_MISALIGN_EXC_EN
    ,
    .id_exc        (id_exc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned nchk, nerr, cyc_n, fires, last_due, lat_min, lat_max;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  logic [31:0] exp_pc, pc_model;
  logic        sb_en;
  logic        c_req_vld, c_jmp, c_rel, c_idv, c_exc;
  logic [31:0] c_addr, c_nxt, c_idpc, c_idinst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample at negedge+1, advance pc model after posedge.
  task automatic cyc(input logic rdy, input logic idr, input logic rv, input logic [31:0] tgt);
    logic        rsp_now, acc;
    int unsigned due;
    imem_req_rdy = rdy;
    id_rdy       = idr;
    redir_vld    = rv;
    redir_tgt    = tgt;
    rsp_now      = 1'b0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc_n) begin
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = ~pend_addr[0];
      rsp_now       = 1'b1;
    end else begin
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = '0;
    end
    #1;
    c_req_vld = imem_req_vld;
    c_addr    = imem_req_addr;
    c_jmp     = pc_jmp;
    c_rel     = pc_rel;
    c_nxt     = pc_nxt;
    c_idv     = id_vld;
    c_idpc    = id_pc;
    c_idinst  = id_inst;
`ifdef IFETCH_MISALIGN_EXC_EN
    c_exc     = id_exc;
`else
    c_exc     = 1'b0;
`endif
    if (c_idv && idr) begin
      fires++;
      if (sb_en) begin
        chk("sb_pc", c_idpc, exp_pc);
        chk("sb_inst", c_idinst, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (rv) exp_pc = tgt;
    acc = c_req_vld && rdy;
    @(posedge clk);
    #1;
    if (rsp_now) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (acc) begin
      due = cyc_n + $urandom_range(lat_max, lat_min);
      if (pend_due.size() != 0 && last_due >= due) due = last_due + 1;
      pend_addr.push_back(c_addr);
      pend_due.push_back(due);
      last_due = due;
    end
    if (c_jmp) pc_model = c_rel ? pc_model + c_nxt : c_nxt;
    else       pc_model = pc_model + 32'd4;
    pc_cur = pc_model;
    chk("inflight_le_max", {31'b0, pend_addr.size() <= MAX_OUT}, 32'd1);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic quiesce();
    repeat (6) cyc(1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    int unsigned f0;
    nchk = 0; nerr = 0; cyc_n = 0; fires = 0; last_due = 0;
    lat_min = 1; lat_max = 1;
    sb_en = 1'b1; exp_pc = '0; pc_model = '0;
    rst = 1'b1; pc_cur = '0; redir_vld = 1'b0; redir_tgt = '0;
    imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rsp_data = '0; id_rdy = 1'b0;
    repeat (2) @(negedge clk);
    imem_req_rdy = 1'b1;
    #1;
    chk("rst_id_vld", {31'b0, id_vld}, 32'd0);
    chk("rst_req_vld", {31'b0, imem_req_vld}, 32'd0);
    chk("rst_pc_jmp", {31'b0, pc_jmp}, 32'd1);
    chk("rst_pc_rel", {31'b0, pc_rel}, 32'd1);
    chk("rst_pc_nxt", pc_nxt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Startup with 1-cycle memory, decode always ready
    cyc(1, 1, 0, '0);
    chk("t1_c0_req", {31'b0, c_req_vld}, 32'd1);
    chk("t1_c0_addr", c_addr, 32'h0);
    chk("t1_c0_jmp", {31'b0, c_jmp}, 32'd0);
    chk("t1_c0_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t1_c1_addr", c_addr, 32'h4);
    chk("t1_c1_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t1_c2_req", {31'b0, c_req_vld}, 32'd0);
    chk("t1_c2_idv", {31'b0, c_idv}, 32'd1);
    chk("t1_c2_idpc", c_idpc, 32'h0);
    chk("t1_c2_hold", {29'b0, c_jmp, c_rel, c_nxt == 0}, 32'd7);
    cyc(1, 1, 0, '0);
    chk("t1_c3_addr", c_addr, 32'h8);
    chk("t1_c3_idpc", c_idpc, 32'h4);
    cyc(1, 1, 0, '0);
    chk("t1_c4_idv", {31'b0, c_idv}, 32'd0);
    chk("t1_c4_addr", c_addr, 32'hC);
    repeat (6) cyc(1, 1, 0, '0);

    // Decode stall: queue fills, requests stop, pc holds; drain in order
    repeat (10) cyc(1, 0, 0, '0);
    chk("t2_req", {31'b0, c_req_vld}, 32'd0);
    chk("t2_hold", {29'b0, c_jmp, c_rel, c_nxt == 0}, 32'd7);
    chk("t2_idv", {31'b0, c_idv}, 32'd1);
    cyc(1, 1, 0, '0);
    chk("t2_r1_idv", {31'b0, c_idv}, 32'd1);
    cyc(1, 1, 0, '0);
    chk("t2_r2_idv", {31'b0, c_idv}, 32'd1);
    cyc(1, 1, 0, '0);
    chk("t2_r3_idv", {31'b0, c_idv}, 32'd0);

    // Redirect to 0x100 with two requests outstanding (latency 3)
    quiesce();
    lat_min = 3; lat_max = 3;
    cyc(1, 1, 0, '0);
    chk("t3_a_addr", c_addr, exp_pc);
    cyc(1, 1, 0, '0);
    chk("t3_b_addr", c_addr, exp_pc + 32'd4);
    cyc(1, 1, 1, 32'h100);
    chk("t3_c_req", {31'b0, c_req_vld}, 32'd0);
    chk("t3_c_ctl", {30'b0, c_jmp, c_rel}, 32'd2);
    chk("t3_c_nxt", c_nxt, 32'h100);
    cyc(1, 1, 0, '0);
    chk("t3_d_req", {31'b0, c_req_vld}, 32'd0);
    chk("t3_d_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t3_e_addr", c_addr, 32'h100);
    chk("t3_e_req", {31'b0, c_req_vld}, 32'd1);
    chk("t3_e_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t3_f_addr", c_addr, 32'h104);
    cyc(1, 1, 0, '0);
    chk("t3_g_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t3_h_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t3_i_idv", {31'b0, c_idv}, 32'd1);
    chk("t3_i_idpc", c_idpc, 32'h100);

    // Redirect coinciding with a response and a decode pop
    lat_min = 1; lat_max = 1;
    cyc(1, 1, 0, '0);
    chk("t4_j_idpc", c_idpc, 32'h104);
    chk("t4_j_addr", c_addr, 32'h108);
    cyc(1, 1, 0, '0);
    chk("t4_k_idv", {31'b0, c_idv}, 32'd0);
    chk("t4_k_addr", c_addr, 32'h10C);
    cyc(1, 1, 1, 32'h200);
    chk("t4_l_idv", {31'b0, c_idv}, 32'd1);
    chk("t4_l_idpc", c_idpc, 32'h108);
    chk("t4_l_req", {31'b0, c_req_vld}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t4_m_idv", {31'b0, c_idv}, 32'd0);
    chk("t4_m_addr", c_addr, 32'h200);
    cyc(1, 1, 0, '0);
    chk("t4_n_idv", {31'b0, c_idv}, 32'd0);
    cyc(1, 1, 0, '0);
    chk("t4_o_idv", {31'b0, c_idv}, 32'd1);
    chk("t4_o_idpc", c_idpc, 32'h200);

`ifdef IFETCH_MISALIGN_EXC_EN
    // Misaligned redirect target yields one NOP entry flagged as exception
    quiesce();
    cyc(1, 0, 1, 32'h102);
    cyc(1, 0, 0, '0);
    chk("t6_x2_req", {31'b0, c_req_vld}, 32'd0);
    chk("t6_x2_hold", {29'b0, c_jmp, c_rel, c_nxt == 0}, 32'd7);
    cyc(1, 0, 0, '0);
    chk("t6_x3_idv", {31'b0, c_idv}, 32'd1);
    chk("t6_x3_idpc", c_idpc, 32'h102);
    chk("t6_x3_inst", c_idinst, 32'h13);
    chk("t6_x3_exc", {31'b0, c_exc}, 32'd1);
    sb_en = 1'b0;
    cyc(1, 1, 0, '0);
    chk("t6_x4_req", {31'b0, c_req_vld}, 32'd0);
    sb_en = 1'b1;
    cyc(1, 1, 0, '0);
    chk("t6_x5_idv", {31'b0, c_idv}, 32'd0);
    chk("t6_x5_req", {31'b0, c_req_vld}, 32'd0);
    cyc(1, 1, 1, 32'h300);
    cyc(1, 1, 0, '0);
    chk("t6_x7_addr", c_addr, 32'h300);
    chk("t6_x7_req", {31'b0, c_req_vld}, 32'd1);
`endif

    // Random ready/latency: scoreboard enforces sequential PCs
    lat_min = 1; lat_max = 3;
    f0 = fires;
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0), 1'b0, '0);
    chk("t5_progress", {31'b0, (fires - f0) > 40}, 32'd1);

    // Reset with entries buffered and requests outstanding
    lat_min = 1; lat_max = 1;
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    rst = 1'b1;
    imem_rsp_vld = 1'b0;
    #1;
    chk("rst2_id_vld", {31'b0, id_vld}, 32'd0);
    chk("rst2_req_vld", {31'b0, imem_req_vld}, 32'd0);
    chk("rst2_hold", {29'b0, pc_jmp, pc_rel, pc_nxt == 0}, 32'd7);
    pend_addr.delete();
    pend_due.delete();
    pc_model = '0; pc_cur = '0; exp_pc = '0; last_due = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, '0);
    chk("rst2_addr", c_addr, 32'h0);
    chk("rst2_req", {31'b0, c_req_vld}, 32'd1);
    repeat (6) cyc(1, 1, 0, '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
